logen_ncntr: RTL
================

# logen_ncntr

Digital LO-divider edge counter on the counter side of the LOGEN LDO calibration loop. It counts rising edges of the divided LO clock inside a window opened and closed by the calibration controller's `cntr_rstn`, `cntr_en` and `cntr_datasyn` strobes. On `cntr_datasyn` it publishes the count as `ncntr`, which drives the controller's `a2d_ncntr` input. It sits between the LOGEN divider output and the calibration FSM, replacing the analog-side counter in digital builds and models.

## Interface
- `CNT_W`, 14: counter and `ncntr` width.
- `SYNC_STAGES`, 2: synchronizer depth for `lo_div_in` (≥2).
- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low.
- `cntr_rstn` in 1: counter clear, active-low, sampled on `clk`.
- `cntr_en` in 1: count window enable, level.
- `cntr_datasyn` in 1: one-cycle latch strobe.
- `lo_div_in` in 1: asynchronous divided LO clock.
- `ncntr` out CNT_W: latched count.
- `ncntr_vld` out 1: latched count valid.
- `ncntr_ovf` out 1: latched overflow flag.

## Operation
- Input path:
  - `lo_div_in` passes through `SYNC_STAGES` flops, then one history flop.
  - `rise` = sync & ~history.
- The raw counter (`CNT_W`) and sticky raw overflow are internal.
- FSM states:
  - IDLE: `cntr_en`=1 → CNT.
  - CNT: each `rise` increments the raw counter. `cntr_en`=0 → HOLD.
  - HOLD: `cntr_datasyn`=1 → IDLE. `cntr_en`=1 → CNT; accumulation continues with no clear.
- `cntr_rstn`=0: raw counter, raw overflow and `ncntr_vld` go to 0, state → IDLE. `ncntr` and `ncntr_ovf` hold.
- `cntr_datasyn`=1 in any state:
  - `ncntr` ← raw counter, `ncntr_ovf` ← raw overflow, `ncntr_vld` ← 1.
  - The raw counter is not cleared.
- Priority: `rstn` > `cntr_rstn` > `cntr_datasyn` > FSM/count.
- Simultaneous `rise` and `cntr_datasyn` in CNT: the latched value excludes that edge; the raw counter still increments.
- `rise` is counted only when the state is CNT in that cycle.
- `cntr_en` high with `cntr_rstn` low: clear wins; CNT is entered the next cycle if `cntr_en` is still high.
- Reset values: `ncntr`=0, `ncntr_vld`=0, `ncntr_ovf`=0, state IDLE, synchronizer/history flops 0.

## Timing
- A `lo_div_in` rise first sampled at edge N asserts `rise` in the cycle after edge N+SYNC_STAGES−1. The raw counter updates at edge N+SYNC_STAGES.
- `cntr_en` sampled high at edge M → CNT from edge M. Sampled low at edge K → HOLD from edge K. The window is exactly K−M cycles.
- `cntr_datasyn` sampled at edge D → `ncntr`, `ncntr_ovf` and `ncntr_vld` valid after edge D (1-cycle latency).
- `cntr_rstn` sampled low at edge R → `ncntr_vld`=0 after edge R.
- `lo_div_in` high and low phases must each be ≥ 1 `clk` period plus synchronizer margin; max countable rate is clk/2.

## Configuration
- `LOGEN_NCNTR_SAT_EN` defined:
  - The raw counter saturates at 2^CNT_W−1.
  - Raw overflow sets on the first `rise` at that saturated value.
- Undefined:
  - The raw counter wraps to 0.
  - Raw overflow sets on the wrap.
- In both cases raw overflow is sticky until `cntr_rstn` or `rstn`.

## Structure
- Package `logen_pkg`:
  - FSM state enum (IDLE/CNT/HOLD, 2 bits).
  - `LOGEN_NCNTR_W`=14 default constant.
- Sub-module `logen_sync_edge`: parameterized synchronizer plus rising-edge detector, reusable for other LOGEN async inputs.

## Test plan
- Basic window:
  - Stimulus: `lo_div_in` period 4 clk, free-running; `cntr_en` high 40 cycles; then `cntr_datasyn`.
  - Response: `ncntr`=10, `ncntr_vld`=1, `ncntr_ovf`=0 one cycle after `cntr_datasyn`.
- Clear mid-count:
  - Stimulus: count 5 edges, pulse `cntr_rstn` low 1 cycle, count 3 more, `cntr_datasyn`.
  - Response: `ncntr_vld` drops after the clear; final `ncntr`=3.
- Overflow:
  - Stimulus: `lo_div_in` period 2 clk, `cntr_en` 33000 cycles, `cntr_datasyn`.
  - Response with macro: `ncntr`=16383, `ncntr_ovf`=1.
  - Response without macro: `ncntr`=116, `ncntr_ovf`=1.
- Snapshot in CNT:
  - Stimulus: `cntr_datasyn` after 4 edges while `cntr_en` stays high, 4 more edges, second `cntr_datasyn`.
  - Response: first `ncntr`=4, second `ncntr`=8.
- Reset mid-operation:
  - Stimulus: `rstn` low 1 cycle during CNT.
  - Response: `ncntr`=0, `ncntr_vld`=0, `ncntr_ovf`=0, state IDLE; counting resumes only on a fresh `cntr_en` sample.
- Static input:
  - Stimulus: `lo_div_in` held high across a 40-cycle window.
  - Response: `ncntr`=0 after `cntr_datasyn`.

Source files
------------

// File: rtl/logen_pkg.sv
// Shared LOGEN definitions: counter FSM state encoding and default widths.
package logen_pkg;

  // Default width of the LO-divider edge counter and its published count
  localparam int unsigned LOGEN_NCNTR_W = 14;

  // Default synchronizer depth for asynchronous LOGEN inputs
  localparam int unsigned LOGEN_SYNC_STAGES = 2;

  // Count-window FSM state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CNT  = 2'd1,
    ST_HOLD = 2'd2
  } ncntr_state_e;

endpackage : logen_pkg

// File: rtl/logen_ncntr_if.sv
// Control strobes from the calibration controller and the published count back to it.
interface logen_ncntr_if
  import logen_pkg::*;
#(
  parameter int unsigned CNT_W = LOGEN_NCNTR_W
) ();

  logic             cntr_rstn;
  logic             cntr_en;
  logic             cntr_datasyn;
  logic [CNT_W-1:0] ncntr;
  logic             ncntr_vld;
  logic             ncntr_ovf;

  // Calibration controller side
  modport master (
    output cntr_rstn,
    output cntr_en,
    output cntr_datasyn,
    input  ncntr,
    input  ncntr_vld,
    input  ncntr_ovf
  );

  // Edge-counter side
  modport slave (
    input  cntr_rstn,
    input  cntr_en,
    input  cntr_datasyn,
    output ncntr,
    output ncntr_vld,
    output ncntr_ovf
  );

endinterface : logen_ncntr_if

// File: rtl/logen_sync_edge.sv
// Multi-flop synchronizer followed by a history flop and rising-edge detector.
// STAGES must be at least 2. rise_c is high for one clk cycle per synchronized rise.
module logen_sync_edge
  import logen_pkg::*;
#(
  parameter int unsigned STAGES = LOGEN_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the async input through the synchronizer chain, then into the history flop
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~hist_q;

endmodule : logen_sync_edge

// File: rtl/logen_ncntr.sv
// LOGEN LO-divider edge counter for the LDO calibration loop.
// Counts synchronized rising edges of lo_div_in while the window FSM is in CNT and
// publishes the raw count on cntr_datasyn.
// Build option: define LOGEN_NCNTR_SAT_EN to saturate the raw counter instead of wrapping.
module logen_ncntr
  import logen_pkg::*;
#(
  parameter int unsigned CNT_W       = LOGEN_NCNTR_W,
  parameter int unsigned SYNC_STAGES = LOGEN_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 lo_div_in,
  logen_ncntr_if.slave         bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ncntr_state_e     state_q;
  ncntr_state_e     state_d;
  logic             rise_c;
  logic             cnt_inc_c;
  logic [CNT_W-1:0] raw_q;
  logic             raw_ovf_q;
  logic [CNT_W-1:0] ncntr_q;
  logic             ncntr_vld_q;
  logic             ncntr_ovf_q;

  logen_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rstn   (rstn),
    .din    (lo_div_in),
    .rise_c (rise_c)
  );

  // An edge only counts when the window is open in the cycle it is seen
  assign cnt_inc_c = (state_q == ST_CNT) && rise_c;

  // Window FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Window FSM next state; the counter clear forces IDLE over any enable
  always_comb begin
    state_d = state_q;
    if (!bus.cntr_rstn) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.cntr_en) state_d = ST_CNT;
        ST_CNT:  if (!bus.cntr_en) state_d = ST_HOLD;
        ST_HOLD: begin
          if (bus.cntr_datasyn) begin
            state_d = ST_IDLE;
          end else if (bus.cntr_en) begin
            state_d = ST_CNT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Raw counter, sticky overflow and the published snapshot; snapshot takes the pre-increment value
  always_ff @(posedge clk) begin
    if (!rstn) begin
      raw_q       <= '0;
      raw_ovf_q   <= 1'b0;
      ncntr_q     <= '0;
      ncntr_vld_q <= 1'b0;
      ncntr_ovf_q <= 1'b0;
    end else if (!bus.cntr_rstn) begin
      raw_q       <= '0;
      raw_ovf_q   <= 1'b0;
      ncntr_vld_q <= 1'b0;
    end else begin
      if (bus.cntr_datasyn) begin
        ncntr_q     <= raw_q;
        ncntr_ovf_q <= raw_ovf_q;
        ncntr_vld_q <= 1'b1;
      end
      if (cnt_inc_c) begin
`ifdef LOGEN_NCNTR_SAT_EN
        if (raw_q == CNT_MAX) begin
          raw_ovf_q <= 1'b1;
        end else begin
          raw_q <= raw_q + CNT_W'(1);
        end
`else
        if (raw_q == CNT_MAX) begin
          raw_ovf_q <= 1'b1;
        end
        raw_q <= raw_q + CNT_W'(1);
`endif
      end
    end
  end

  assign bus.ncntr     = ncntr_q;
  assign bus.ncntr_vld = ncntr_vld_q;
  assign bus.ncntr_ovf = ncntr_ovf_q;

endmodule : logen_ncntr
